// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and width helper for the sequential multiplier
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mul_state_t;

    localparam int MUL_N_DEFAULT = 16;

    // Product width for an n-bit by n-bit multiply.
    function automatic int prod_w(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/cond_neg.sv
// rtl/cond_neg.sv - conditional two's-complement negation
// Ports:
//   en   in   1  negate when high
//   in   in   W  operand
//   out  out  W  en ? -in : in
module cond_neg #(
    parameter int W = 16
) (
    input  logic         en,
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);

    assign out = en ? (~in + W'(1)) : in;

endmodule

// File: rtl/seq_mul_sm.sv
// rtl/seq_mul_sm.sv - sequential shift-add multiplier with sign by magnitude and early exit
// Ports:
//   clk   in   1   clock, rising edge
//   rst   in   1   asynchronous active-low reset
//   strt  in   1   start request, sampled only in IDLE
//   sgn   in   1   1 = signed operands, 0 = unsigned; sampled with strt
//   a     in   N   multiplicand
//   b     in   N   multiplier
//   res   out  2N  product, held between operations
//   busy  out  1   operation in flight
//   done  out  1   one-cycle pulse, res valid in the same cycle
module seq_mul_sm
    import mul_pkg::*;
#(
    parameter int N = MUL_N_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 strt,
    input  logic                 sgn,
    input  logic [N-1:0]         a,
    input  logic [N-1:0]         b,
    output logic [prod_w(N)-1:0] res,
    output logic                 busy,
    output logic                 done
);

    localparam int PW = prod_w(N);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    mul_state_t    state;
    logic [PW-1:0] mc;
    logic [N-1:0]  mp;
    logic [PW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          neg;

    logic [N-1:0]  abs_a;
    logic [N-1:0]  abs_b;
    logic [PW-1:0] acc_fix;

    // Magnitudes; 2^(N-1) negates to itself, which is correct read as unsigned.
    cond_neg #(.W(N)) u_abs_a (
        .en  (sgn & a[N-1]),
        .in  (a),
        .out (abs_a)
    );

    cond_neg #(.W(N)) u_abs_b (
        .en  (sgn & b[N-1]),
        .in  (b),
        .out (abs_b)
    );

    cond_neg #(.W(PW)) u_fix (
        .en  (neg),
        .in  (acc),
        .out (acc_fix)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            mc    <= '0;
            mp    <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            res   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (strt) begin
                        mc    <= {{(PW - N){1'b0}}, abs_a};
                        mp    <= abs_b;
                        acc   <= '0;
                        cnt   <= '0;
                        neg   <= sgn & (a[N-1] ^ b[N-1]);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (mp[0]) begin
                        acc <= acc + mc;
                    end
                    mc  <= mc << 1;
                    mp  <= mp >> 1;
                    cnt <= cnt + CW'(1);
                    // Exit once no set multiplier bits remain after this shift.
                    if ((mp[N-1:1] == '0) || (cnt == CNT_LAST)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    res   <= acc_fix;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_sm.sv
// tb/tb_seq_mul_sm.sv - randomized self-checking bench for seq_mul_sm
module tb_seq_mul_sm;

    localparam int N = 16;

    logic          clk;
    logic          rst;
    logic          strt;
    logic          sgn;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [2*N-1:0] res;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;
    logic [2*N-1:0] prev_res = '0;

    seq_mul_sm #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .strt (strt),
        .sgn  (sgn),
        .a    (a),
        .b    (b),
        .res  (res),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*N-1:0] ref_prod(input logic s, input logic [N-1:0] x, input logic [N-1:0] y);
        longint p;
        logic [63:0] pv;
        if (s) p = longint'($signed(x)) * longint'($signed(y));
        else   p = longint'({1'b0, x}) * longint'({1'b0, y});
        pv = p;
        return pv[2*N-1:0];
    endfunction

    function automatic int ref_latency(input logic s, input logic [N-1:0] y);
        int mb;
        int nb;
        mb = (s && y[N-1]) ? ((1 << N) - int'(y)) : int'(y);
        nb = 0;
        while ((mb >> nb) != 0) nb++;
        return ((nb < 1) ? 1 : nb) + 2;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen.
    // poke > 0 raises strt with fresh operands in that cycle of the operation.
    task automatic run_op(input logic s, input logic [N-1:0] x, input logic [N-1:0] y, input int poke);
        logic [2*N-1:0] exp;
        int lat;
        int n;
        bit seen;
        exp  = ref_prod(s, x, y);
        lat  = ref_latency(s, y);
        sgn  = s;
        a    = x;
        b    = y;
        strt = 1'b1;
        n    = 0;
        seen = 0;
        while (!seen && n < 3 * N) begin
            @(negedge clk);
            n++;
            if (n == poke) begin
                strt = 1'b1;
                sgn  = $urandom_range(0, 1);
                a    = $urandom;
                b    = $urandom;
            end else begin
                strt = 1'b0;
                a    = $urandom;
                b    = $urandom;
            end
            if (done) begin
                seen = 1;
                check("latency", 64'(n), 64'(lat));
                check("res", 64'(res), 64'(exp));
                check("busy_at_done", 64'(busy), 64'd0);
            end else begin
                check("busy_running", 64'(busy), 64'd1);
                check("res_held", 64'(res), 64'(prev_res));
            end
        end
        strt = 1'b0;
        if (!seen) check("done_timeout", 64'd0, 64'd1);
        prev_res = exp;
    endtask

    initial begin
        int stray;
        rst  = 1'b0;
        strt = 1'b0;
        sgn  = 1'b0;
        a    = '0;
        b    = '0;
        repeat (3) @(negedge clk);
        check("reset_res", 64'(res), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_op(1'b1, 16'hFFFD, 16'h0005, 0);
        check("t1_res", 64'(res), 64'hFFFF_FFF1);
        @(negedge clk);
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 0);
        check("t2_res", 64'(res), 64'hFFFE_0001);
        @(negedge clk);
        run_op(1'b1, 16'h8000, 16'h8000, 0);
        check("t3_res", 64'(res), 64'h4000_0000);
        run_op(1'b1, 16'h8000, 16'h0001, 0);
        check("t3b_res", 64'(res), 64'hFFFF_8000);
        run_op(1'b0, 16'h1234, 16'h0000, 0);
        run_op(1'b1, 16'h1234, 16'h0000, 0);
        // strt in the done cycle
        run_op(1'b0, 16'h0002, 16'h0003, 0);
        check("t4_res", 64'(res), 64'd6);
        @(negedge clk);
        // strt mid-RUN is ignored
        run_op(1'b1, 16'h1357, 16'hF00D, 3);
        run_op(1'b0, 16'h0000, 16'hABCD, 2);

        // Reset mid-operation
        @(negedge clk);
        sgn  = 1'b1;
        a    = 16'hFFF9;
        b    = 16'h00FF;
        strt = 1'b1;
        @(negedge clk);
        strt = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_res", 64'(res), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        check("no_stray_done", 64'(stray), 64'd0);
        prev_res = '0;
        run_op(1'b1, 16'hFFF9, 16'h00FF, 0);
        check("t6_res", 64'(res), 64'hFFFF_F907);

        // Randomized operations with varied multiplier widths and gaps
        for (int i = 0; i < 60; i++) begin
            logic [N-1:0] rx;
            logic [N-1:0] ry;
            logic         rs;
            int           w;
            int           gap;
            rs  = $urandom_range(0, 1);
            rx  = $urandom;
            w   = $urandom_range(0, N);
            ry  = $urandom;
            if (w < N) ry = ry & N'((1 << w) - 1);
            if ($urandom_range(0, 3) == 0) ry = ~ry;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check("idle_done", 64'(done), 64'd0);
            end
            run_op(rs, rx, ry, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0);
        end

        @(negedge clk);
        check("final_done_clear", 64'(done), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
